// File: rtl/mul_result_packer.sv
// Pairs multiplier result words into a word FIFO and frames each product
// as header, high word, low word on the RAH transmit write port.
module mul_result_packer #(
    parameter int         RAH_PACKET_WIDTH = 48,
    parameter int         DEPTH            = 8,
    parameter logic [7:0] APP_ID           = 8'h02
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic [RAH_PACKET_WIDTH-1:0] in_data,
    input  logic                        in_wren,
    output logic [RAH_PACKET_WIDTH-1:0] wr_data,
    output logic                        wr_en,
    input  logic                        wr_full,
    output logic                        overflow,
    output logic [15:0]                 seq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, HI, LO} state_t;

    logic [RAH_PACKET_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               rptr;
    logic [CW-1:0]               count;
    logic                        phase;
    logic                        keep;
    state_t                      state;

    logic free_ok;
    logic push;
    logic pop;

    // Room for a whole pair is reserved when the high word arrives
    assign free_ok = (count <= CW'(DEPTH - 2));
    assign push    = in_wren & (phase ? keep : free_ok);
    assign pop     = (state != IDLE) & ~wr_full;

    function automatic logic [AW-1:0] bump(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= in_data;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            phase    <= 1'b0;
            keep     <= 1'b0;
            overflow <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
        end else begin
            if (in_wren) begin
                phase <= ~phase;
                if (!phase) begin
                    keep <= free_ok;
                    if (!free_ok) overflow <= 1'b1;
                end
            end
            if (push) wptr <= bump(wptr);
            if (pop)  rptr <= bump(rptr);
            if (push && !pop)      count <= count + CW'(1);
            else if (pop && !push) count <= count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state   <= IDLE;
            wr_en   <= 1'b0;
            wr_data <= '0;
            seq     <= '0;
        end else begin
            wr_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (count >= CW'(2) && !wr_full) begin
                        wr_data <= {APP_ID, seq, 24'd2};
                        wr_en   <= 1'b1;
                        state   <= HI;
                    end
                end
                HI: begin
                    if (!wr_full) begin
                        wr_data <= mem[rptr];
                        wr_en   <= 1'b1;
                        state   <= LO;
                    end
                end
                LO: begin
                    if (!wr_full) begin
                        wr_data <= mem[rptr];
                        wr_en   <= 1'b1;
                        seq     <= seq + 16'd1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mul_result_packer.sv
// Randomised and directed bench for mul_result_packer against a
// packet-stream model of the framing and admission rules.
module tb_mul_result_packer;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [47:0] in_data = '0;
    logic        in_wren = 1'b0;
    logic [47:0] wr_data;
    logic        wr_en;
    logic        wr_full = 1'b0;
    logic        overflow;
    logic [15:0] seq;

    int checks = 0;
    int errors = 0;

    mul_result_packer #(
        .RAH_PACKET_WIDTH(48),
        .DEPTH(DEPTH),
        .APP_ID(8'h02)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .in_data(in_data),
        .in_wren(in_wren),
        .wr_data(wr_data),
        .wr_en(wr_en),
        .wr_full(wr_full),
        .overflow(overflow),
        .seq(seq)
    );

    always #5 clk = ~clk;

    // Model: expected packet stream plus admission bookkeeping
    logic [47:0] exp_q[$];
    int          occ = 0;
    int          pos = 0;
    bit          m_phase = 0;
    bit          m_keep = 0;
    bit          m_ovf = 0;
    logic [15:0] m_seq = 0;
    logic [15:0] h_seq = 0;

    bit          s_r, s_w, s_f;
    logic [47:0] s_d;
    logic [47:0] e;

    task automatic check(input string name, input logic [47:0] act,
                         input logic [47:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    always @(posedge clk) begin
        s_r = rstn; s_w = in_wren; s_f = wr_full; s_d = in_data;
        #1;
        if (!s_r) begin
            exp_q.delete();
            occ = 0; pos = 0; m_phase = 0; m_keep = 0; m_ovf = 0;
            m_seq = 0; h_seq = 0;
        end else begin
            if (s_w) begin
                if (!m_phase) begin
                    m_keep = (DEPTH - occ >= 2);
                    if (m_keep) begin
                        exp_q.push_back({8'h02, h_seq, 24'd2});
                        exp_q.push_back(s_d);
                        h_seq++;
                        occ++;
                    end else m_ovf = 1;
                end else if (m_keep) begin
                    exp_q.push_back(s_d);
                    occ++;
                end
                m_phase = ~m_phase;
            end
            if (wr_en) begin
                checks++;
                if (s_f) begin
                    errors++;
                    $display("FAIL wr_en_while_full: got 1 expected 0");
                end
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_packet: got %h expected none",
                             wr_data);
                end else begin
                    e = exp_q.pop_front();
                    check("packet", wr_data, e);
                    if (pos % 3 != 0) occ--;
                    if (pos % 3 == 2) m_seq++;
                    pos++;
                end
            end
            check("overflow", 48'(overflow), 48'(m_ovf));
            check("seq", 48'(seq), 48'(m_seq));
        end
    end

    task automatic send_pair(input logic [47:0] hi, input logic [47:0] lo);
        @(negedge clk); in_wren = 1'b1; in_data = hi;
        @(negedge clk); in_data = lo;
        @(negedge clk); in_wren = 1'b0;
    endtask

    task automatic drain();
        @(negedge clk); wr_full = 1'b0;
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0 || occ != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
    endtask

    initial begin
        #1;
        check("rst_wr_en", 48'(wr_en), 48'd0);
        check("rst_wr_data", wr_data, 48'd0);
        check("rst_seq", 48'(seq), 48'd0);
        check("rst_overflow", 48'(overflow), 48'd0);
        @(negedge clk); @(negedge clk); rstn = 1'b1;

        // Single product, literal timing
        send_pair(48'h1, 48'h2);
        @(posedge clk); #1;
        check("single_hdr_en", 48'(wr_en), 48'd1);
        check("single_hdr", wr_data, 48'h02_0000_000002);
        @(posedge clk); #1;
        check("single_hi_en", 48'(wr_en), 48'd1);
        check("single_hi", wr_data, 48'h1);
        @(posedge clk); #1;
        check("single_lo_en", 48'(wr_en), 48'd1);
        check("single_lo", wr_data, 48'h2);
        check("single_seq", 48'(seq), 48'd1);
        check("single_ovf", 48'(overflow), 48'd0);
        drain();

        // Backpressure
        @(negedge clk); wr_full = 1'b1;
        send_pair(48'hAAAA_0000_1111, 48'hBBBB_0000_2222);
        repeat (10) @(negedge clk);
        wr_full = 1'b0;
        @(posedge clk); #1;
        check("bp_hdr", wr_data, 48'h02_0001_000002);
        check("bp_hdr_en", 48'(wr_en), 48'd1);
        drain();

        // Push and pop overlapping
        for (int i = 0; i < 20; i++) begin
            send_pair({16'hC0DE, 32'(i)}, {16'hF00D, 32'(i * 7)});
            repeat (3) @(negedge clk);
            checks++;
            if (occ > 4) begin
                errors++;
                $display("FAIL pushpop_occ: got %0d expected <=4", occ);
            end
        end
        drain();

        // Sequence wrap
        @(negedge clk);
        force dut.seq = 16'hFFFF;
        m_seq = 16'hFFFF; h_seq = 16'hFFFF;
        @(negedge clk);
        release dut.seq;
        send_pair(48'h123, 48'h456);
        @(posedge clk); #1;
        check("wrap_hdr_ffff", wr_data, 48'h02_FFFF_000002);
        drain();
        send_pair(48'h789, 48'hABC);
        @(posedge clk); #1;
        check("wrap_hdr_0000", wr_data, 48'h02_0000_000002);
        drain();

        // Overflow: 5 pairs into an 8-word FIFO under backpressure
        @(negedge clk); wr_full = 1'b1;
        for (int i = 0; i < 5; i++)
            send_pair({24'hABCDEF, 24'(i)}, {24'h654321, 24'(i)});
        check("ovf_flag", 48'(overflow), 48'd1);
        check("ovf_pending", 48'(exp_q.size()), 48'd12);
        drain();

        // Reset while stalled in HI
        @(negedge clk); wr_full = 1'b0;
        send_pair(48'h5555, 48'h6666);
        @(posedge clk); #1;
        check("rmf_hdr_en", 48'(wr_en), 48'd1);
        wr_full = 1'b1;
        @(negedge clk); @(negedge clk);
        check("rmf_ovf_pre", 48'(overflow), 48'd1);
        rstn = 1'b0;
        #1;
        check("rmf_wr_en", 48'(wr_en), 48'd0);
        check("rmf_wr_data", wr_data, 48'd0);
        check("rmf_seq", 48'(seq), 48'd0);
        check("rmf_ovf", 48'(overflow), 48'd0);
        @(negedge clk); @(negedge clk);
        rstn = 1'b1; wr_full = 1'b0;
        send_pair(48'h7777, 48'h8888);
        @(posedge clk); #1;
        check("rmf_new_hdr", wr_data, 48'h02_0000_000002);
        drain();

        // Random traffic
        for (int i = 0; i < 60; i++) begin
            send_pair({$urandom(), 16'($urandom())},
                      {$urandom(), 16'($urandom())});
            repeat ($urandom_range(0, 4)) begin
                @(negedge clk);
                wr_full = ($urandom_range(0, 2) == 0);
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
